alu_result_framer: RTL and testbench
====================================

// Module: alu_result_framer
// PURPOSE
//   Downstream stage of the ALU's registered result/flag outputs. Captures each
//   valid ALU result and streams it as DATA_WIDTH-wide bytes over a valid/ready
//   handshake into the TX FIFO write port. Byte order is LSB first.
//   Holds one extra result in a pending slot so back-to-back ALU ops are not
//   lost while a frame is still draining.
// PARAMETERS
//   DATA_WIDTH  8   width of one outgoing byte (FIFO data width)
//   RES_WIDTH   16  ALU result width; must be an integer multiple of DATA_WIDTH
//   NBYTES      RES_WIDTH/DATA_WIDTH (localparam, derived; not overridable)
// PORTS
//   CLK        in   1           system clock (ALU/REF domain)
//   RST        in   1           synchronous reset, active-high
//   ALU_OUT    in   RES_WIDTH   registered ALU result
//   OUT_VALID  in   1           1-cycle pulse: ALU_OUT holds a new result
//   TX_READY   in   1           FIFO can accept a byte this cycle (not full)
//   TX_DATA    out  DATA_WIDTH  outgoing byte
//   TX_VALID   out  1           TX_DATA is valid; a byte transfers on a CLK edge where TX_VALID && TX_READY
//   BUSY       out  1           frame in flight or pending slot occupied
//   OVERRUN    out  1           1-cycle pulse: an incoming result was dropped
// BEHAVIOUR
//   Reset (sync, RST=1 at posedge): TX_DATA=0, TX_VALID=0, BUSY=0, OVERRUN=0,
//     FSM=IDLE, byte index=0, pending slot empty. Reset mid-frame drops the
//     frame and the pending result; no remaining bytes are sent.
//   FSM states: IDLE, SEND.
//   IDLE: OUT_VALID=1 -> load ALU_OUT into shift reg, index=0, go SEND.
//     Latency: TX_VALID=1 with byte 0 on the cycle after the OUT_VALID pulse.
//   SEND: TX_VALID=1; TX_DATA = shift_reg[idx*DATA_WIDTH +: DATA_WIDTH].
//     TX_READY=0 -> hold; TX_DATA and TX_VALID stay stable (no retraction).
//     Transfer with idx<NBYTES-1 -> idx+1; TX_VALID stays 1.
//     Transfer with idx==NBYTES-1 (last byte):
//       pending full   -> load pending into shift reg, idx=0, stay SEND (no bubble)
//       else OUT_VALID -> load ALU_OUT directly, idx=0, stay SEND
//       else           -> go IDLE, TX_VALID=0, TX_DATA holds last value
//   OUT_VALID while in SEND (not consumed by the last-byte rule above):
//     pending empty -> store ALU_OUT in pending slot
//     pending full  -> drop new result, OVERRUN=1 for exactly one cycle
//   Simultaneous last-byte transfer + pending full + OUT_VALID: pending moves to
//     shift reg, new result enters pending; no OVERRUN.
//   BUSY = (state==SEND) | pending_valid, registered alongside state.
//   Throughput: NBYTES cycles per result with TX_READY held high.
//   OUT_VALID held high for several cycles is treated as one result per cycle.
// STRUCTURE
//   Single module, no sub-modules. NBYTES and the byte-index width
//   ($clog2(NBYTES), minimum 1) are computed locally.
//   ALU result width and the default DATA_WIDTH belong in the shared ALU
//   constants package, next to the ALU_FUN encodings, so the ALU and this
//   block stay consistent.
//   FSM state encoding is local to this block.
// TESTING (RES_WIDTH=16, DATA_WIDTH=8 unless noted)
//   1 Single op: ALU_OUT=16'hA55A, OUT_VALID pulse, TX_READY=1 -> 8'h5A then 8'hA5
//     on consecutive cycles; TX_VALID low on the next cycle; BUSY falls to 0.
//   2 Backpressure: TX_READY=0 for 5 cycles after TX_VALID rises -> TX_DATA=8'h5A
//     stable, TX_VALID=1 throughout; bytes complete once TX_READY returns to 1.
//   3 Back-to-back: OUT_VALID for 16'h1234 then 16'hBEEF one cycle apart,
//     TX_READY=1 -> 34,12,EF,BE with no gap; OVERRUN never set.
//   4 Overrun: TX_READY=0; three OUT_VALID pulses (0x0001,0x0002,0x0003) ->
//     OVERRUN pulses once on the third; release TX_READY -> 01,00,02,00 only.
//   5 Reset mid-frame: assert RST after byte 0 transfers -> next cycle
//     TX_VALID=0, BUSY=0; following single op framed normally from byte 0.
//   6 RES_WIDTH=32: ALU_OUT=32'hDEADBEEF -> EF,BE,AD,DE; last byte with
//     simultaneous OUT_VALID chains the next frame with no bubble.

Source files
------------

// File: rtl/alu_result_framer_pkg.sv
// Shared ALU constants: result width, outgoing byte width and ALU_FUN encodings.
// The ALU and its downstream framer both import this so their widths agree.
package alu_result_framer_pkg;

  localparam int ALU_RES_WIDTH  = 16;
  localparam int ALU_DATA_WIDTH = 8;

  typedef enum logic [3:0] {
    ALU_FUN_ADD = 4'h0,
    ALU_FUN_SUB = 4'h1,
    ALU_FUN_AND = 4'h2,
    ALU_FUN_OR  = 4'h3,
    ALU_FUN_XOR = 4'h4,
    ALU_FUN_NOT = 4'h5,
    ALU_FUN_SHL = 4'h6,
    ALU_FUN_SHR = 4'h7,
    ALU_FUN_CMP = 4'h8
  } alu_fun_e;

endpackage

// File: rtl/alu_result_framer.sv
// Streams each valid ALU result as LSB-first bytes over a valid/ready port,
// with one pending slot so a result arriving mid-frame is not lost.
module alu_result_framer
  import alu_result_framer_pkg::*;
#(
  parameter int DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int RES_WIDTH  = ALU_RES_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [RES_WIDTH-1:0]  ALU_OUT,
  input  logic                  OUT_VALID,
  input  logic                  TX_READY,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_VALID,
  output logic                  BUSY,
  output logic                  OVERRUN,
  output logic                  DBG_STATE
);

  localparam int NBYTES = RES_WIDTH / DATA_WIDTH;
  localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Handshake: a byte moves on a CLK edge where TX_VALID && TX_READY; once
  // TX_VALID is raised, TX_VALID and TX_DATA hold until that transfer happens.

  state_e               r_state;
  state_e               w_state_nxt;
  logic [RES_WIDTH-1:0] r_shift;
  logic [RES_WIDTH-1:0] w_shift_nxt;
  logic [RES_WIDTH-1:0] r_pend;
  logic [RES_WIDTH-1:0] w_pend_nxt;
  logic                 r_pend_valid;
  logic                 w_pend_valid_nxt;
  logic [IDX_W-1:0]     r_idx;
  logic [IDX_W-1:0]     w_idx_nxt;
  logic                 r_busy;
  logic                 r_overrun;
  logic                 w_overrun_nxt;
  logic                 w_xfer;
  logic                 w_last;

  assign w_xfer = (r_state == SEND) && TX_READY;
  assign w_last = (r_idx == LAST_IDX);

  always_comb begin
    w_state_nxt      = r_state;
    w_shift_nxt      = r_shift;
    w_pend_nxt       = r_pend;
    w_pend_valid_nxt = r_pend_valid;
    w_idx_nxt        = r_idx;
    w_overrun_nxt    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (OUT_VALID) begin
          w_shift_nxt = ALU_OUT;
          w_idx_nxt   = '0;
          w_state_nxt = SEND;
        end
      end
      SEND: begin
        if (w_xfer && !w_last) begin
          w_idx_nxt = r_idx + 1'b1;
        end
        if (w_xfer && w_last) begin
          // Frame boundary: the pending result goes first, a fresh one may refill pending.
          if (r_pend_valid) begin
            w_shift_nxt      = r_pend;
            w_idx_nxt        = '0;
            w_pend_valid_nxt = OUT_VALID;
            if (OUT_VALID) begin
              w_pend_nxt = ALU_OUT;
            end
          end else if (OUT_VALID) begin
            w_shift_nxt = ALU_OUT;
            w_idx_nxt   = '0;
          end else begin
            w_state_nxt = IDLE;
          end
        end else if (OUT_VALID) begin
          if (!r_pend_valid) begin
            w_pend_nxt       = ALU_OUT;
            w_pend_valid_nxt = 1'b1;
          end else begin
            w_overrun_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_shift      <= '0;
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_idx        <= '0;
      r_busy       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_pend       <= w_pend_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_idx        <= w_idx_nxt;
      r_busy       <= (w_state_nxt == SEND) | w_pend_valid_nxt;
      r_overrun    <= w_overrun_nxt;
    end
  end

  // In IDLE the index and shift register are left alone, so the last byte stays on TX_DATA.
  assign TX_DATA   = r_shift[r_idx*DATA_WIDTH +: DATA_WIDTH];
  assign TX_VALID  = (r_state == SEND);
  assign BUSY      = r_busy;
  assign OVERRUN   = r_overrun;
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_alu_result_framer.sv
// Bench for alu_result_framer: 16-bit and 32-bit instances share one stimulus
// stream, each checked by a result-level reference model and byte scoreboard.
module tb_alu_result_framer;
  import alu_result_framer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        out_valid = 1'b0;
  logic        tx_ready = 1'b0;
  logic [31:0] alu_out = '0;
  int          checks = 0;
  int          failures = 0;

  logic [1:0]  busy_v;
  logic [1:0]  txv_v;
  logic [1:0]  ovr_v;
  logic [7:0]  txd_v [2];

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_cfg
    localparam int RW = (g == 0) ? 16 : 32;
    localparam int NB = RW / 8;

    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          busy;
    logic          overrun;
    logic          dbg_state;

    // Model: a DUT holds at most two results (one draining, one waiting).
    logic [RW-1:0] held [$];
    logic [7:0]    exp_q [$];
    int            sent = 0;
    logic          exp_ovr = 1'b0;
    logic          seen_valid = 1'b0;
    logic [7:0]    seen_data = '0;
    logic          model_xfer;
    logic          hold_chk;
    logic [RW-1:0] v;

    alu_result_framer #(.DATA_WIDTH(8), .RES_WIDTH(RW)) dut (
      .CLK       (clk),
      .RST       (rst),
      .ALU_OUT   (alu_out[RW-1:0]),
      .OUT_VALID (out_valid),
      .TX_READY  (tx_ready),
      .TX_DATA   (tx_data),
      .TX_VALID  (tx_valid),
      .BUSY      (busy),
      .OVERRUN   (overrun),
      .DBG_STATE (dbg_state)
    );

    assign busy_v[g] = busy;
    assign txv_v[g]  = tx_valid;
    assign ovr_v[g]  = overrun;
    assign txd_v[g]  = tx_data;

    always @(posedge clk) begin
      exp_ovr    = 1'b0;
      model_xfer = (held.size() > 0) && tx_ready;
      hold_chk   = !rst && seen_valid && !tx_ready;
      if (rst) begin
        held.delete();
        exp_q.delete();
        sent = 0;
      end else begin
        if (model_xfer) begin
          if (exp_q.size() == 0) check($sformatf("w%0d_byte_unexpected", RW), 1, 0);
          else check($sformatf("w%0d_byte", RW), seen_data, exp_q.pop_front());
          sent++;
          if (sent == NB) begin
            void'(held.pop_front());
            sent = 0;
          end
        end
        if (out_valid) begin
          if (held.size() < 2) begin
            v = alu_out[RW-1:0];
            held.push_back(v);
            for (int k = 0; k < NB; k++) exp_q.push_back(8'(v >> (8 * k)));
          end else begin
            exp_ovr = 1'b1;
          end
        end
      end
      #1;
      check($sformatf("w%0d_tx_valid", RW), tx_valid, held.size() > 0);
      check($sformatf("w%0d_busy", RW), busy, held.size() > 0);
      check($sformatf("w%0d_overrun", RW), overrun, exp_ovr);
      if (hold_chk) begin
        check($sformatf("w%0d_hold_valid", RW), tx_valid, 1'b1);
        check($sformatf("w%0d_hold_data", RW), tx_data, seen_data);
      end
      seen_valid = tx_valid;
      seen_data  = tx_data;
    end
  end

  task automatic pulse(input logic [31:0] val);
    alu_out   = val;
    out_valid = 1'b1;
    @(negedge clk);
    out_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((busy_v != 2'b00 || txv_v != 2'b00) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(name, n < 300, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_tx_data_%0d", i), txd_v[i], 8'h00);
      check($sformatf("reset_tx_valid_%0d", i), txv_v[i], 1'b0);
      check($sformatf("reset_busy_%0d", i), busy_v[i], 1'b0);
      check($sformatf("reset_overrun_%0d", i), ovr_v[i], 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);

    // single op
    tx_ready = 1'b1;
    pulse(32'h0000_A55A);
    wait_idle("single_idle");
    check("single_last_byte_held", txd_v[0], 8'hA5);

    // backpressure after TX_VALID rises
    tx_ready = 1'b0;
    pulse(32'h0000_A55A);
    check("bp_first_byte", txd_v[0], 8'h5A);
    repeat (5) @(negedge clk);
    tx_ready = 1'b1;
    wait_idle("bp_idle");

    // back-to-back, adjacent and one cycle apart
    pulse(32'h0000_1234);
    pulse(32'h0000_BEEF);
    wait_idle("b2b_idle");
    pulse(32'h0000_1234);
    @(negedge clk);
    pulse(32'h0000_BEEF);
    wait_idle("b2b_gap_idle");

    // overrun on the third result
    tx_ready = 1'b0;
    pulse(32'h0000_0001);
    pulse(32'h0000_0002);
    pulse(32'h0000_0003);
    repeat (3) @(negedge clk);
    tx_ready = 1'b1;
    wait_idle("overrun_idle");

    // reset after byte 0 has transferred
    pulse(32'h0000_A55A);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midreset_tx_valid", txv_v, 2'b00);
    check("midreset_busy", busy_v, 2'b00);
    rst = 1'b0;
    pulse(32'h0000_C33C);
    wait_idle("midreset_idle");

    // 32-bit frame chained on its last byte, then OUT_VALID held high
    pulse(32'hDEAD_BEEF);
    repeat (3) @(negedge clk);
    pulse(32'h1122_3344);
    wait_idle("chain_idle");
    pulse(32'h0BAD_F00D);
    pulse(32'h5566_7788);
    pulse(32'h99AA_BBCC);
    pulse(32'hCAFE_D00D);
    wait_idle("held_valid_idle");

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      out_valid = ($urandom_range(0, 3) == 0);
      alu_out   = $urandom;
      tx_ready  = ($urandom_range(0, 9) < 7);
      rst       = ($urandom_range(0, 249) == 0);
      @(negedge clk);
    end
    out_valid = 1'b0;
    rst       = 1'b0;
    tx_ready  = 1'b1;
    wait_idle("random_idle");
    check("final_tx_valid", txv_v, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
